// File: rtl/crossing_pkg.sv
// Shared types and limits for the toggle-handshake register crossing.
package crossing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  function automatic bit sync_stages_legal(input int unsigned n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/crossing_reg_rx_if.sv
// Source-word, destination handshake and ack signals of one register crossing.
interface crossing_reg_rx_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] s_data;
  logic             s_toggle;
  logic [WIDTH-1:0] d_data;
  logic             d_valid;
  logic             d_ready;
  logic             ack_toggle;
  logic             err;

  modport master (
    output s_data, s_toggle, d_ready,
    input  d_data, d_valid, ack_toggle, err
  );

  modport slave (
    input  s_data, s_toggle, d_ready,
    output d_data, d_valid, ack_toggle, err
  );

endinterface

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous reset; shared with the source-side ack receiver.
module sync_bit
  import crossing_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  if (!sync_stages_legal(STAGES)) begin : g_bad_stages
    $error("sync_bit: STAGES must be within 2..4");
  end

  // Pure shift chain: nothing may sit between the stages.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/crossing_reg_rx.sv
// Destination end of a toggle-handshake register crossing.
// Optional protocol checker enabled by defining CROSSING_RX_CHECK_EN.
module crossing_reg_rx
  import crossing_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}},
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  crossing_reg_rx_if.slave io_bus
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
    $error("crossing_reg_rx: SYNC_STAGES must be within 2..4");
  end

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_togSync;
  logic             r_togLast;
  logic             w_edge;
  logic             w_capture;
  logic             w_accept;
  logic [WIDTH-1:0] r_dData;
  logic             r_dValid;
  logic             r_ack;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .i_d (io_bus.s_toggle),
    .o_q (w_togSync)
  );

  // tog_last only advances on capture, so edges are ignored while holding a word.
  assign w_edge = w_togSync ^ r_togLast;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_capture   = 1'b1;
          w_stateNext = HOLD;
        end
      end
      HOLD: begin
        if (io_bus.d_ready) begin
          w_accept    = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_togLast <= 1'b0;
      r_dData   <= INIT;
      r_dValid  <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_dData   <= io_bus.s_data;
        r_togLast <= w_togSync;
        r_dValid  <= 1'b1;
      end
      if (w_accept) begin
        r_dValid <= 1'b0;
        r_ack    <= ~r_ack;
      end
    end
  end

  assign io_bus.d_data     = r_dData;
  assign io_bus.d_valid    = r_dValid;
  assign io_bus.ack_toggle = r_ack;

`ifdef CROSSING_RX_CHECK_EN
  logic r_err;
  logic r_togPrev;
  logic r_holdFlip;
  logic r_dblFlip;
  logic w_togChg;
  logic w_errSet;

  assign w_togChg = w_togSync ^ r_togPrev;
  assign w_errSet = ((r_state == HOLD) && w_edge) ||
                    (r_dblFlip && io_bus.d_ready && !r_dValid);

  // Counts request flips seen while holding so a double flip stays visible after it cancels out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err      <= 1'b0;
      r_togPrev  <= 1'b0;
      r_holdFlip <= 1'b0;
      r_dblFlip  <= 1'b0;
    end else begin
      r_togPrev <= w_togSync;
      if (w_capture) begin
        r_holdFlip <= 1'b0;
      end else if ((r_state == HOLD) && w_togChg) begin
        r_holdFlip <= 1'b1;
        if (r_holdFlip) begin
          r_dblFlip <= 1'b1;
        end
      end
      if (w_errSet) begin
        r_err <= 1'b1;
      end
    end
  end

  assign io_bus.err = r_err;

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (!RST && w_errSet && !r_err) begin
      $display("crossing_reg_rx: protocol violation at %0t, d_data=%h", $time, r_dData);
    end
  end
`endif
`else
  assign io_bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_crossing_reg_rx.sv
// Randomized self-checking bench for crossing_reg_rx against a transaction-level model.
module tb_crossing_reg_rx;

  localparam int         WIDTH       = 8;
  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] INIT        = 8'h00;
`ifdef CROSSING_RX_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;

  crossing_reg_rx_if #(.WIDTH(WIDTH)) bus ();

  crossing_reg_rx #(
    .WIDTH       (WIDTH),
    .INIT        (INIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .io_bus (bus)
  );

  always #5 CLK = ~CLK;

  int         testsRun    = 0;
  int         testsFailed = 0;
  logic       expAck;
  logic       expErr;
  logic [7:0] expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, bus.d_valid}, 32'd0);
    checkOutput({tag, "_ack"}, {31'd0, bus.ack_toggle}, {31'd0, expAck});
    checkOutput({tag, "_err"}, {31'd0, bus.err}, {31'd0, expErr});
  endtask

  // Waits (bounded) for d_valid and checks it arrived exactly SYNC_STAGES+1 edges after the flip.
  task automatic waitValid(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.d_valid && n < 20);
    checkOutput(tag, n, SYNC_STAGES + 1);
  endtask

  // One complete word transfer: flip, capture, optional backpressure, accept, idle gap.
  task automatic applyStimulus(input logic [7:0] word, input int readyDelay, input int gap);
    logic [7:0] want;
    expQ.push_back(word);
    bus.s_data   = word;
    bus.s_toggle = ~bus.s_toggle;
    bus.d_ready  = (readyDelay == 0);
    waitValid("latency");
    want = expQ.pop_front();
    checkOutput("data", {24'd0, bus.d_data}, {24'd0, want});
    checkOutput("ackBeforeAccept", {31'd0, bus.ack_toggle}, {31'd0, expAck});
    bus.s_data = 8'($urandom);
    for (int i = 0; i < readyDelay; i++) begin
      tick();
      checkOutput("holdValid", {31'd0, bus.d_valid}, 32'd1);
      checkOutput("holdData", {24'd0, bus.d_data}, {24'd0, want});
      checkOutput("holdAck", {31'd0, bus.ack_toggle}, {31'd0, expAck});
    end
    bus.d_ready = 1'b1;
    tick();
    expAck = ~expAck;
    checkOutput("acceptValid", {31'd0, bus.d_valid}, 32'd0);
    checkOutput("ackFlip", {31'd0, bus.ack_toggle}, {31'd0, expAck});
    bus.d_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < gap; i++) begin
      tick();
      checkIdle("gap");
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.s_data   = 8'h00;
    bus.s_toggle = 1'b0;
    bus.d_ready  = 1'b0;
    RST          = 1'b1;
    expAck       = 1'b0;
    expErr       = 1'b0;
    repeat (3) tick();
    checkOutput("rstValid", {31'd0, bus.d_valid}, 32'd0);
    checkOutput("rstData", {24'd0, bus.d_data}, {24'd0, INIT});
    checkOutput("rstAck", {31'd0, bus.ack_toggle}, 32'd0);
    checkOutput("rstErr", {31'd0, bus.err}, 32'd0);
    RST = 1'b0;

    // Quiet source after reset: nothing may appear.
    for (int i = 0; i < 8; i++) begin
      bus.d_ready = 1'($urandom_range(0, 1));
      tick();
      checkIdle("initQuiet");
    end

    applyStimulus(8'hA5, 0, 2);
    applyStimulus(8'hA5, 10, 2);
    applyStimulus(8'h01, 0, 0);
    applyStimulus(8'h02, 0, 0);
    applyStimulus(8'h03, 0, 0);
    checkOutput("b2bAckFinal", {31'd0, bus.ack_toggle}, 32'd1);

    for (int k = 0; k < 20; k++) begin
      applyStimulus(8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    // Reset while a word is held: word dropped, ack returns to 0.
    bus.s_data   = 8'h3C;
    bus.s_toggle = ~bus.s_toggle;
    bus.d_ready  = 1'b0;
    waitValid("rstHoldLatency");
    checkOutput("rstHoldData", {24'd0, bus.d_data}, 32'h3C);
    RST          = 1'b1;
    bus.s_toggle = 1'b0;
    tick();
    expAck = 1'b0;
    checkOutput("midRstValid", {31'd0, bus.d_valid}, 32'd0);
    checkOutput("midRstData", {24'd0, bus.d_data}, {24'd0, INIT});
    checkOutput("midRstAck", {31'd0, bus.ack_toggle}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkIdle("postRst");
    end
    applyStimulus(8'h96, 1, 1);

    // Double flip while holding: flagged by the checker, and lost after accept.
    bus.s_data   = 8'h5A;
    bus.s_toggle = ~bus.s_toggle;
    bus.d_ready  = 1'b0;
    waitValid("violLatency");
    bus.s_toggle = ~bus.s_toggle;
    repeat (4) tick();
    bus.s_toggle = ~bus.s_toggle;
    expErr = CHECK_EN;
    repeat (SYNC_STAGES + 1) tick();
    checkOutput("errSet", {31'd0, bus.err}, {31'd0, expErr});
    checkOutput("violHoldValid", {31'd0, bus.d_valid}, 32'd1);
    checkOutput("violHoldData", {24'd0, bus.d_data}, 32'h5A);
    bus.d_ready = 1'b1;
    tick();
    expAck = ~expAck;
    checkOutput("violAcceptAck", {31'd0, bus.ack_toggle}, {31'd0, expAck});
    bus.d_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkIdle("dblLost");
    end

    // Single extra flip while holding: becomes the next word right after accept.
    bus.s_data   = 8'h77;
    bus.s_toggle = ~bus.s_toggle;
    waitValid("singleLatency");
    bus.s_data   = 8'hC3;
    bus.s_toggle = ~bus.s_toggle;
    repeat (4) tick();
    checkOutput("singleHoldData", {24'd0, bus.d_data}, 32'h77);
    bus.d_ready = 1'b1;
    tick();
    expAck = ~expAck;
    checkOutput("singleAcceptAck", {31'd0, bus.ack_toggle}, {31'd0, expAck});
    bus.d_ready = 1'b0;
    tick();
    checkOutput("extraWordValid", {31'd0, bus.d_valid}, 32'd1);
    checkOutput("extraWordData", {24'd0, bus.d_data}, 32'hC3);
    checkOutput("errSticky", {31'd0, bus.err}, {31'd0, expErr});
    bus.d_ready = 1'b1;
    tick();
    expAck = ~expAck;
    checkOutput("extraAcceptAck", {31'd0, bus.ack_toggle}, {31'd0, expAck});

    // Reset clears the sticky error.
    RST          = 1'b1;
    bus.s_toggle = 1'b0;
    bus.d_ready  = 1'b0;
    tick();
    RST    = 1'b0;
    expAck = 1'b0;
    expErr = 1'b0;
    tick();
    checkIdle("finalRst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
